// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC configuration sequencer.
// Holds the sequencer state enum, the decimation-select limit and the saturating-increment helper.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        SETTLE  = 2'd1,
        RUN     = 2'd2,
        QUIESCE = 2'd3
    } cic_seq_state_t;

    localparam logic [2:0] SEL_MAX = 3'd4;

    function automatic logic [2:0] clamp_sel(input logic [2:0] sel);
        return (sel > SEL_MAX) ? SEL_MAX : sel;
    endfunction

    // Saturating increment for any counter up to 16 bits wide; w is the counter width.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned w);
        logic [15:0] top;
        top = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 32'd1);
        return (v >= top) ? top : v + 16'd1;
    endfunction

endpackage

// File: rtl/cic_cfg_sequencer.sv
// Applies CIC decimation/bypass changes at frame boundaries: flush, transient suppression, overflow supervision.
// Control outputs are registered (1 cycle); sample strobes are gated combinationally; cfg_ready only in RUN.
module cic_cfg_sequencer
    import cic_ctrl_pkg::*;
#(
    parameter int N_STAGES     = 3,
    parameter int RST_CYC      = 2,
    parameter int QUIET_TO     = 64,
    parameter int INIT_SEL     = 0,
    parameter int AUTO_RECOVER = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_decim_sel,
    input  logic       cfg_enable,
    input  logic       in_valid,
    output logic       cic_in_valid,
    output logic [2:0] cic_decim_sel,
    output logic       cic_in_enable,
    output logic       cic_sync_reset,
    input  logic       cic_out_valid,
    input  logic [5:0] cic_ovf_flags,
    output logic       out_valid,
    output logic       busy,
    output logic       ovf_irq,
    output logic [7:0] ovf_cnt,
    output logic [15:0] drop_cnt
);

    localparam int RW = $clog2(RST_CYC + 1);
    localparam int QW = $clog2(QUIET_TO + 1);
    localparam int SW = $clog2(N_STAGES + 1);
    localparam logic [2:0] INIT_SEL_C = clamp_sel(3'(INIT_SEL));

    cic_seq_state_t state, state_nxt;

    logic [2:0]    pend_sel, pend_sel_nxt;
    logic          pend_en, pend_en_nxt;
    logic [RW-1:0] rst_cnt;
    logic [QW-1:0] q_cnt;
    logic [SW-1:0] s_cnt;
    logic          ovf_any, ovf_prev, ovf_evt;
    logic          cfg_hs, enter_flush;

    assign cfg_hs      = cfg_valid & cfg_ready;
    assign ovf_any     = |cic_ovf_flags;
    assign ovf_evt     = (state == RUN) & ovf_any & ~ovf_prev;
    assign enter_flush = (state_nxt == FLUSH) && (state != FLUSH);

    assign cic_in_valid = in_valid & (state != FLUSH);
    assign out_valid    = cic_out_valid & ((state == RUN) | (state == QUIESCE));

    always_comb begin
        state_nxt    = state;
        pend_sel_nxt = pend_sel;
        pend_en_nxt  = pend_en;
        case (state)
            RUN: begin
                // A config request outranks an overflow recovery in the same cycle.
                if (cfg_hs) begin
                    pend_sel_nxt = clamp_sel(cfg_decim_sel);
                    pend_en_nxt  = cfg_enable;
                    state_nxt    = cic_in_enable ? QUIESCE : FLUSH;
                end else if (ovf_evt && (AUTO_RECOVER != 0)) begin
                    pend_sel_nxt = cic_decim_sel;
                    pend_en_nxt  = cic_in_enable;
                    state_nxt    = FLUSH;
                end
            end
            QUIESCE: begin
                if (cic_out_valid || (q_cnt == QW'(QUIET_TO - 1)))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (rst_cnt <= RW'(1))
                    state_nxt = SETTLE;
            end
            SETTLE: begin
                // Bypass has no comb transient to wait out.
                if (!cic_in_enable)
                    state_nxt = RUN;
                else if (cic_out_valid && (s_cnt == SW'(N_STAGES - 1)))
                    state_nxt = RUN;
            end
            default: state_nxt = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= FLUSH;
            pend_sel       <= INIT_SEL_C;
            pend_en        <= 1'b1;
            rst_cnt        <= RW'(RST_CYC);
            q_cnt          <= '0;
            s_cnt          <= '0;
            cic_decim_sel  <= INIT_SEL_C;
            cic_in_enable  <= 1'b1;
            cic_sync_reset <= 1'b1;
            cfg_ready      <= 1'b0;
            busy           <= 1'b1;
            ovf_prev       <= 1'b0;
            ovf_irq        <= 1'b0;
            ovf_cnt        <= '0;
            drop_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            pend_sel       <= pend_sel_nxt;
            pend_en        <= pend_en_nxt;
            cfg_ready      <= (state_nxt == RUN);
            busy           <= (state_nxt != RUN);
            cic_sync_reset <= (state_nxt == FLUSH);

            if (enter_flush) begin
                cic_decim_sel <= pend_sel_nxt;
                cic_in_enable <= pend_en_nxt;
                rst_cnt       <= RW'(RST_CYC);
            end else if ((state == FLUSH) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - RW'(1);
            end

            if (state != QUIESCE)
                q_cnt <= '0;
            else
                q_cnt <= q_cnt + QW'(1);

            if (state != SETTLE)
                s_cnt <= '0;
            else if (cic_out_valid)
                s_cnt <= s_cnt + SW'(1);

            ovf_prev <= ovf_any;
            ovf_irq  <= ovf_evt;
            if (ovf_evt)
                ovf_cnt <= 8'(sat_inc(16'(ovf_cnt), 8));
            if ((state == FLUSH) && in_valid)
                drop_cnt <= sat_inc(drop_cnt, 16);
        end
    end

endmodule

// File: tb/tb_cic_cfg_sequencer.sv
// Randomized scoreboard bench for cic_cfg_sequencer against a phase-level reference model.
module tb_cic_cfg_sequencer;

    localparam int N_STAGES     = 3;
    localparam int RST_CYC      = 2;
    localparam int QUIET_TO     = 64;
    localparam int INIT_SEL     = 2;
    localparam int AUTO_RECOVER = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_ready, cfg_enable;
    logic [2:0]  cfg_decim_sel;
    logic        in_valid, cic_in_valid;
    logic [2:0]  cic_decim_sel;
    logic        cic_in_enable, cic_sync_reset, cic_out_valid;
    logic [5:0]  cic_ovf_flags;
    logic        out_valid, busy, ovf_irq;
    logic [7:0]  ovf_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    cic_cfg_sequencer #(
        .N_STAGES(N_STAGES), .RST_CYC(RST_CYC), .QUIET_TO(QUIET_TO),
        .INIT_SEL(INIT_SEL), .AUTO_RECOVER(AUTO_RECOVER)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_decim_sel(cfg_decim_sel), .cfg_enable(cfg_enable),
        .in_valid(in_valid), .cic_in_valid(cic_in_valid),
        .cic_decim_sel(cic_decim_sel), .cic_in_enable(cic_in_enable),
        .cic_sync_reset(cic_sync_reset), .cic_out_valid(cic_out_valid),
        .cic_ovf_flags(cic_ovf_flags), .out_valid(out_valid),
        .busy(busy), .ovf_irq(ovf_irq), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic        cfg_ready, busy, sync_reset, in_enable, civ, ov, irq;
        logic [2:0]  sel;
        int          oc, dc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which phase of a reconfiguration we are in, plus the visible registers.
    typedef enum {M_RUN, M_WAIT, M_FLUSH, M_SETTLE} mph_t;
    mph_t       m_ph;
    logic [2:0] m_sel, m_psel;
    logic       m_en, m_pen, m_ovf_prev, m_irq;
    int         m_left, m_quiet, m_strobes, m_oc, m_dc;
    logic [5:0] cur_flags;

    task automatic model_reset();
        m_ph = M_FLUSH; m_left = RST_CYC;
        m_sel = 3'(INIT_SEL); m_psel = 3'(INIT_SEL); m_en = 1'b1; m_pen = 1'b1;
        m_ovf_prev = 1'b0; m_irq = 1'b0; m_oc = 0; m_dc = 0;
        m_quiet = 0; m_strobes = 0;
    endtask

    task automatic start_flush();
        m_ph = M_FLUSH; m_sel = m_psel; m_en = m_pen; m_left = RST_CYC;
    endtask

    task automatic model_eval();
        exp_t e;
        logic evt;
        if (!reset) model_reset();
        e.cfg_ready  = (m_ph == M_RUN);
        e.busy       = (m_ph != M_RUN);
        e.sync_reset = (m_ph == M_FLUSH);
        e.sel        = m_sel;
        e.in_enable  = m_en;
        e.civ        = in_valid && (m_ph != M_FLUSH);
        e.ov         = cic_out_valid && (m_ph == M_RUN || m_ph == M_WAIT);
        e.irq        = m_irq;
        e.oc         = m_oc;
        e.dc         = m_dc;
        exp_q.push_back(e);
        if (!reset) return;

        evt = (m_ph == M_RUN) && (cic_ovf_flags != 6'd0) && !m_ovf_prev;
        m_ovf_prev = (cic_ovf_flags != 6'd0);
        m_irq = evt;
        if (evt && m_oc < 255) m_oc++;
        if (m_ph == M_FLUSH && in_valid && m_dc < 65535) m_dc++;

        case (m_ph)
            M_RUN: begin
                if (cfg_valid) begin
                    m_psel = (cfg_decim_sel > 3'd4) ? 3'd4 : cfg_decim_sel;
                    m_pen  = cfg_enable;
                    if (m_en) begin m_ph = M_WAIT; m_quiet = 0; end
                    else start_flush();
                end else if (evt && AUTO_RECOVER != 0) begin
                    m_psel = m_sel; m_pen = m_en;
                    start_flush();
                end
            end
            M_WAIT: begin
                m_quiet++;
                if (cic_out_valid || m_quiet >= QUIET_TO) start_flush();
            end
            M_FLUSH: begin
                m_left--;
                if (m_left == 0) begin m_ph = M_SETTLE; m_strobes = 0; end
            end
            M_SETTLE: begin
                if (!m_en) m_ph = M_RUN;
                else if (cic_out_valid) begin
                    m_strobes++;
                    if (m_strobes == N_STAGES) m_ph = M_RUN;
                end
            end
            default: ;
        endcase
    endtask

    function automatic bit pct(int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic drive_cycle(input logic rst, input int p_iv, input int p_cov, input int p_cfg,
                               input int p_cen, input int p_flag, input bit alt_flags);
        @(posedge clk);
        #1;
        reset         = rst;
        in_valid      = pct(p_iv);
        cic_out_valid = pct(p_cov);
        cfg_valid     = pct(p_cfg);
        cfg_decim_sel = 3'($urandom_range(0, 7));
        cfg_enable    = pct(p_cen);
        if (alt_flags)
            cur_flags = (cur_flags == 6'd0) ? 6'($urandom_range(1, 63)) : 6'd0;
        else if (pct(p_flag))
            cur_flags = pct(50) ? 6'd0 : 6'($urandom_range(1, 63));
        cic_ovf_flags = cur_flags;
        model_eval();
    endtask

    task automatic run_seg(input int n, input int p_iv, input int p_cov, input int p_cfg,
                           input int p_cen, input int p_flag, input bit alt_flags);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b1, p_iv, p_cov, p_cfg, p_cen, p_flag, alt_flags);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cfg_ready",      int'(cfg_ready),      int'(e.cfg_ready));
            chk("busy",           int'(busy),           int'(e.busy));
            chk("cic_sync_reset", int'(cic_sync_reset), int'(e.sync_reset));
            chk("cic_decim_sel",  int'(cic_decim_sel),  int'(e.sel));
            chk("cic_in_enable",  int'(cic_in_enable),  int'(e.in_enable));
            chk("cic_in_valid",   int'(cic_in_valid),   int'(e.civ));
            chk("out_valid",      int'(out_valid),      int'(e.ov));
            chk("ovf_irq",        int'(ovf_irq),        int'(e.irq));
            chk("ovf_cnt",        int'(ovf_cnt),        e.oc);
            chk("drop_cnt",       int'(drop_cnt),       e.dc);
        end
    end

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_decim_sel = 3'd0; cfg_enable = 1'b1;
        in_valid = 1'b0; cic_out_valid = 1'b0; cic_ovf_flags = 6'd0; cur_flags = 6'd0;
        model_reset();

        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 70, 20, 0, 100, 0, 1'b0);
        // Settle-only start, then general traffic.
        run_seg(40, 80, 20, 0, 100, 0, 1'b0);
        run_seg(600, 75, 17, 3, 88, 2, 1'b0);
        // No frame boundaries and no samples: quiesce must time out.
        run_seg(300, 0, 0, 10, 100, 0, 1'b0);
        run_seg(37, 60, 25, 5, 90, 2, 1'b0);
        // Reset in the middle of whatever sequence is running.
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 90, 30, 50, 50, 0, 1'b0);
        run_seg(400, 75, 17, 4, 88, 2, 1'b0);
        run_seg(500, 70, 20, 12, 50, 2, 1'b0);
        run_seg(500, 70, 30, 2, 90, 10, 1'b0);
        // Rapid overflow toggling to drive ovf_cnt into saturation.
        run_seg(4000, 60, 50, 0, 100, 0, 1'b1);
        run_seg(200, 75, 17, 5, 80, 3, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
